// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Score and level accumulator feeding game_screen. Accepts
//               line-clear events, adds the configured points to a 4-digit
//               BCD score one point per cycle, and counts cleared lines to
//               raise the fall velocity.
//               Optional feature macro: SCORE_SATURATE_EN (score holds at
//               9999 instead of wrapping to 0000).
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper #(
  parameter logic [3:0] POINTS_1        = 4'd1,
  parameter logic [3:0] POINTS_2        = 4'd3,
  parameter logic [3:0] POINTS_3        = 4'd5,
  parameter logic [3:0] POINTS_4        = 4'd8,
  parameter logic [3:0] LINES_PER_LEVEL = 4'd10,
  parameter logic [1:0] START_VELOCITY  = 2'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       restart,
  input  logic       clear_valid,
  input  logic [2:0] clear_count,
  output logic       clear_ready,
  output logic [3:0] digit_thsnd,
  output logic [3:0] digit_hndrd,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_units,
  output logic [1:0] velocity,
  output logic       score_max
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    LEVEL = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // Event bookkeeping
  logic [3:0] pts_left;
  logic [3:0] pts_nxt;
  logic [2:0] cnt_q;
  logic [2:0] cnt_nxt;
  logic [3:0] lines_acc;
  logic [3:0] lines_nxt;
  logic [1:0] vel_nxt;
  logic       ready_nxt;

  // Score digits, next values
  logic [3:0] thsnd_nxt;
  logic [3:0] hndrd_nxt;
  logic [3:0] tens_nxt;
  logic [3:0] units_nxt;

  // BCD incrementer results
  logic       units_carry;
  logic       tens_carry;
  logic       hndrd_carry;
  logic [3:0] inc_thsnd;
  logic [3:0] inc_hndrd;
  logic [3:0] inc_tens;
  logic [3:0] inc_units;

  // Decoded clear_count
  logic       cnt_ok;
  logic [3:0] cnt_pts;

  // Line accumulation
  logic [4:0] lines_sum;
  logic       level_hit;
  logic [3:0] lines_wrapped;

  // Score is at its maximum when every digit reads 9
  assign score_max = (digit_thsnd == 4'd9) && (digit_hndrd == 4'd9) &&
                     (digit_tens  == 4'd9) && (digit_units == 4'd9);

  // BCD +1 on the current score; the full carry chain settles in one cycle
  always_comb begin
    units_carry = (digit_units == 4'd9);
    tens_carry  = units_carry && (digit_tens == 4'd9);
    hndrd_carry = tens_carry && (digit_hndrd == 4'd9);

    inc_units = units_carry ? 4'd0 : digit_units + 4'd1;
    inc_tens  = digit_tens;
    inc_hndrd = digit_hndrd;
    inc_thsnd = digit_thsnd;

    if (units_carry) begin
      inc_tens = tens_carry ? 4'd0 : digit_tens + 4'd1;
    end
    if (tens_carry) begin
      inc_hndrd = hndrd_carry ? 4'd0 : digit_hndrd + 4'd1;
    end
    if (hndrd_carry) begin
      // Carry out of the thousands digit is dropped, so 9999 wraps to 0000
      inc_thsnd = (digit_thsnd == 4'd9) ? 4'd0 : digit_thsnd + 4'd1;
    end

`ifdef SCORE_SATURATE_EN
    // Hold at 9999; pts_left keeps counting so busy time is unchanged
    if (score_max) begin
      inc_units = digit_units;
      inc_tens  = digit_tens;
      inc_hndrd = digit_hndrd;
      inc_thsnd = digit_thsnd;
    end
`endif
  end

  // Map the line count of an incoming event to its points and validity
  always_comb begin
    cnt_ok  = 1'b1;
    cnt_pts = 4'd0;
    case (clear_count)
      3'd1:    cnt_pts = POINTS_1;
      3'd2:    cnt_pts = POINTS_2;
      3'd3:    cnt_pts = POINTS_3;
      3'd4:    cnt_pts = POINTS_4;
      default: cnt_ok  = 1'b0;
    endcase
  end

  // Add the latched line count and fold it into a velocity step when full
  always_comb begin
    lines_sum     = {1'b0, lines_acc} + {2'b00, cnt_q};
    level_hit     = (lines_sum >= {1'b0, LINES_PER_LEVEL});
    // The remainder is always below 16, so 4-bit subtraction is exact
    lines_wrapped = lines_sum[3:0] - LINES_PER_LEVEL;
  end

  // Next-state and datapath update; restart overrides everything
  always_comb begin
    state_nxt = state;
    pts_nxt   = pts_left;
    cnt_nxt   = cnt_q;
    lines_nxt = lines_acc;
    vel_nxt   = velocity;
    thsnd_nxt = digit_thsnd;
    hndrd_nxt = digit_hndrd;
    tens_nxt  = digit_tens;
    units_nxt = digit_units;

    if (restart) begin
      state_nxt = IDLE;
      pts_nxt   = 4'd0;
      cnt_nxt   = 3'd0;
      lines_nxt = 4'd0;
      vel_nxt   = START_VELOCITY;
      thsnd_nxt = 4'd0;
      hndrd_nxt = 4'd0;
      tens_nxt  = 4'd0;
      units_nxt = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          // Invalid counts are consumed with no effect
          if (clear_valid && clear_ready && cnt_ok) begin
            cnt_nxt   = clear_count;
            pts_nxt   = cnt_pts;
            state_nxt = (cnt_pts == 4'd0) ? LEVEL : ADD;
          end
        end
        ADD: begin
          thsnd_nxt = inc_thsnd;
          hndrd_nxt = inc_hndrd;
          tens_nxt  = inc_tens;
          units_nxt = inc_units;
          pts_nxt   = pts_left - 4'd1;
          if (pts_left == 4'd1) begin
            state_nxt = LEVEL;
          end
        end
        LEVEL: begin
          if (level_hit) begin
            lines_nxt = lines_wrapped;
            if (velocity != 2'd3) begin
              vel_nxt = velocity + 2'd1;
            end
          end else begin
            lines_nxt = lines_sum[3:0];
          end
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Ready is a registered decode of the upcoming state
    ready_nxt = (state_nxt == IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pts_left    <= 4'd0;
      cnt_q       <= 3'd0;
      lines_acc   <= 4'd0;
      velocity    <= START_VELOCITY;
      clear_ready <= 1'b1;
      digit_thsnd <= 4'd0;
      digit_hndrd <= 4'd0;
      digit_tens  <= 4'd0;
      digit_units <= 4'd0;
    end else begin
      pts_left    <= pts_nxt;
      cnt_q       <= cnt_nxt;
      lines_acc   <= lines_nxt;
      velocity    <= vel_nxt;
      clear_ready <= ready_nxt;
      digit_thsnd <= thsnd_nxt;
      digit_hndrd <= hndrd_nxt;
      digit_tens  <= tens_nxt;
      digit_units <= units_nxt;
    end
  end

endmodule
`default_nettype wire
